// File: rtl/jk_mode_counter.sv
// WIDTH-bit register bank: independent JK flip-flops, or a modulo-MODULUS up/down counter with load.
// tc looks ahead to the coming wrap; wrap is a registered pulse one cycle after it.
module jk_mode_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] J,
  input  logic [WIDTH-1:0] K,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qb,
  output logic             tc,
  output logic             wrap
);

  localparam logic [1:0] MODE_JK   = 2'd0;
  localparam logic [1:0] MODE_UP   = 2'd1;
  localparam logic [1:0] MODE_DOWN = 2'd2;
  localparam logic [1:0] MODE_LOAD = 2'd3;

  // One extra bit so MODULUS = 2^WIDTH still fits.
  localparam logic [WIDTH:0]   MAX_EXT = (WIDTH+1)'(MODULUS - 1);
  localparam logic [WIDTH-1:0] MAX_VAL = MAX_EXT[WIDTH-1:0];

  logic [WIDTH-1:0] q_q, q_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH:0]   q_ext, j_ext;
  logic             at_top, at_zero;

  assign q_ext   = {1'b0, q_q};
  assign j_ext   = {1'b0, J};
  assign at_top  = (q_ext >= MAX_EXT);
  assign at_zero = (q_q == '0);

  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    if (en) begin
      case (mode)
        MODE_JK: q_d = (J & ~q_q) | (~K & q_q);
        MODE_UP: begin
          if (at_top) begin
            q_d    = '0;
            wrap_d = 1'b1;
          end else begin
            q_d = q_q + WIDTH'(1);
          end
        end
        MODE_DOWN: begin
          if (at_zero) begin
            q_d    = MAX_VAL;
            wrap_d = 1'b1;
          end else if (q_ext > MAX_EXT) begin
            // Out of range after JK mode: re-enter at the top without a wrap.
            q_d = MAX_VAL;
          end else begin
            q_d = q_q - WIDTH'(1);
          end
        end
        MODE_LOAD: q_d = (j_ext <= MAX_EXT) ? J : MAX_VAL;
        default: q_d = q_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      q_q    <= '0;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
    end
  end

  assign Q    = q_q;
  assign Qb   = ~q_q;
  assign wrap = wrap_q;
  assign tc   = en & ~rst & (((mode == MODE_UP) & at_top) | ((mode == MODE_DOWN) & at_zero));

endmodule

// File: tb/tb_jk_mode_counter.sv
// Directed bench for jk_mode_counter: MODULUS=10 unit, MODULUS=2 unit and a two-digit decimal cascade.
module tb_jk_mode_counter;

  logic       clock;
  logic       rst;
  logic       en;
  logic [1:0] mode;
  logic [3:0] J, K, Q, Qb;
  logic       tc, wrap;

  logic       m2_en;
  logic [1:0] m2_mode;
  logic [1:0] m2_J, m2_K, m2_Q, m2_Qb;
  logic       m2_tc, m2_wrap;

  logic       c_en;
  logic [1:0] c_mode;
  logic [3:0] c_zero;
  logic [3:0] lo_Q, lo_Qb, hi_Q, hi_Qb;
  logic       lo_tc, lo_wrap, hi_tc, hi_wrap;

  int n_assert = 0;
  int n_fail   = 0;

  jk_mode_counter #(.WIDTH(4), .MODULUS(10)) dut (
    .clock(clock), .rst(rst), .en(en), .mode(mode), .J(J), .K(K),
    .Q(Q), .Qb(Qb), .tc(tc), .wrap(wrap)
  );

  jk_mode_counter #(.WIDTH(2), .MODULUS(2)) dut_m2 (
    .clock(clock), .rst(rst), .en(m2_en), .mode(m2_mode), .J(m2_J), .K(m2_K),
    .Q(m2_Q), .Qb(m2_Qb), .tc(m2_tc), .wrap(m2_wrap)
  );

  jk_mode_counter #(.WIDTH(4), .MODULUS(10)) dut_lo (
    .clock(clock), .rst(rst), .en(c_en), .mode(c_mode), .J(c_zero), .K(c_zero),
    .Q(lo_Q), .Qb(lo_Qb), .tc(lo_tc), .wrap(lo_wrap)
  );

  jk_mode_counter #(.WIDTH(4), .MODULUS(10)) dut_hi (
    .clock(clock), .rst(rst), .en(lo_tc), .mode(c_mode), .J(c_zero), .K(c_zero),
    .Q(hi_Q), .Qb(hi_Qb), .tc(hi_tc), .wrap(hi_wrap)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mode = 2'd0; J = 4'd0; K = 4'd0;
    m2_en = 1'b0; m2_mode = 2'd1; m2_J = 2'd0; m2_K = 2'd0;
    c_en = 1'b0; c_mode = 2'd1; c_zero = 4'd0;
    step();
    step();

    // Reset state; mode=down at Q=0 would raise tc without rst.
    en = 1'b1; mode = 2'd2;
    #1;
    chk("rst_q", 16'(Q), 16'h0);
    chk("rst_qb", 16'(Qb), 16'hF);
    chk("rst_wrap", 16'(wrap), 16'h0);
    chk("rst_tc", 16'(tc), 16'h0);

    // Up-count to 7, then reset mid-count.
    rst = 1'b0; mode = 2'd1;
    for (int i = 1; i <= 7; i++) begin
      step();
      chk("up_to7", 16'(Q), 16'(i));
    end
    rst = 1'b1;
    step();
    chk("midrst_q", 16'(Q), 16'h0);
    chk("midrst_qb", 16'(Qb), 16'hF);
    chk("midrst_wrap", 16'(wrap), 16'h0);
    chk("midrst_tc", 16'(tc), 16'h0);
    rst = 1'b0;
    step();
    chk("rel_q1", 16'(Q), 16'h1);
    step();
    chk("rel_q2", 16'(Q), 16'h2);

    // Up wrap from 0.
    mode = 2'd3; J = 4'd0;
    step();
    chk("load0", 16'(Q), 16'h0);
    mode = 2'd1;
    for (int i = 1; i <= 10; i++) begin
      #1;
      chk("up_tc", 16'(tc), (i == 10) ? 16'h1 : 16'h0);
      step();
      chk("up_q", 16'(Q), 16'(i % 10));
      chk("up_wrap", 16'(wrap), (i == 10) ? 16'h1 : 16'h0);
    end
    step();
    chk("up_after_q", 16'(Q), 16'h1);
    chk("up_after_wrap", 16'(wrap), 16'h0);

    // Reset on an edge that would have wrapped.
    mode = 2'd3; J = 4'd9;
    step();
    mode = 2'd1;
    #1;
    chk("pre_rst_tc", 16'(tc), 16'h1);
    rst = 1'b1;
    step();
    chk("rstwrap_q", 16'(Q), 16'h0);
    chk("rstwrap_wrap", 16'(wrap), 16'h0);
    rst = 1'b0;

    // Down wrap from 0.
    mode = 2'd2;
    #1;
    chk("dn_tc", 16'(tc), 16'h1);
    step();
    chk("dn_q9", 16'(Q), 16'h9);
    chk("dn_wrap", 16'(wrap), 16'h1);
    step();
    chk("dn_q8", 16'(Q), 16'h8);
    chk("dn_wrap_clr", 16'(wrap), 16'h0);

    // JK direct.
    mode = 2'd3; J = 4'b0101;
    step();
    chk("load5", 16'(Q), 16'h5);
    mode = 2'd0; J = 4'b0011; K = 4'b1001;
    #1;
    chk("jk_tc", 16'(tc), 16'h0);
    step();
    chk("jk_q", 16'(Q), 16'b0110);
    J = 4'hD; K = 4'h2;
    step();
    chk("jk_q13", 16'(Q), 16'hD);
    chk("jk_qb13", 16'(Qb), 16'h2);

    // Down from out-of-range: no wrap.
    mode = 2'd2; K = 4'h0;
    #1;
    chk("oor_dn_tc", 16'(tc), 16'h0);
    step();
    chk("oor_dn_q", 16'(Q), 16'h9);
    chk("oor_dn_wrap", 16'(wrap), 16'h0);

    // Up from out-of-range wraps.
    mode = 2'd0; J = 4'hD; K = 4'h0;
    step();
    chk("jk_q13b", 16'(Q), 16'hD);
    mode = 2'd1;
    #1;
    chk("oor_up_tc", 16'(tc), 16'h1);
    step();
    chk("oor_up_q", 16'(Q), 16'h0);
    chk("oor_up_wrap", 16'(wrap), 16'h1);

    // Load and clamp.
    mode = 2'd3; J = 4'd6;
    step();
    chk("ld6", 16'(Q), 16'h6);
    chk("ld6_wrap", 16'(wrap), 16'h0);
    J = 4'd10;
    step();
    chk("ld10", 16'(Q), 16'h9);
    J = 4'd6;
    step();
    J = 4'd12;
    step();
    chk("ld12", 16'(Q), 16'h9);
    en = 1'b0; J = 4'd3;
    step();
    chk("en0_ld", 16'(Q), 16'h9);
    mode = 2'd1;
    #1;
    chk("en0_tc", 16'(tc), 16'h0);
    step();
    chk("en0_up", 16'(Q), 16'h9);
    chk("en0_wrap", 16'(wrap), 16'h0);

    // MODULUS=2 at full speed: wrap every other cycle.
    m2_en = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("m2_q", 16'(m2_Q), 16'(i % 2));
      chk("m2_wrap", 16'(m2_wrap), (i % 2 == 0) ? 16'h1 : 16'h0);
    end
    m2_en = 1'b0;

    // Two-digit decimal cascade.
    chk("cas_lo0", 16'(lo_Q), 16'h0);
    chk("cas_hi0", 16'(hi_Q), 16'h0);
    c_en = 1'b1;
    for (int n = 1; n <= 100; n++) begin
      step();
      chk("cas_lo", 16'(lo_Q), 16'(n % 10));
      chk("cas_hi", 16'(hi_Q), 16'((n / 10) % 10));
      chk("cas_lo_wrap", 16'(lo_wrap), (n % 10 == 0) ? 16'h1 : 16'h0);
      chk("cas_hi_wrap", 16'(hi_wrap), (n == 100) ? 16'h1 : 16'h0);
    end
    c_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/jk_mode_counter.md
# jk_mode_counter

Parametrised successor to the single-bit JK flip-flop: a WIDTH-bit register bank that operates either as WIDTH independent JK flip-flops or as a modulo-MODULUS up/down counter with synchronous load. It is the general-purpose state element for lab sequencers that previously chained discrete JK cells. It provides a terminal-count look-ahead and a registered wrap pulse so that counters can be cascaded.

## Interface
- WIDTH, 4: register width in bits, 1..16.
- MODULUS, 16: count modulus, 2..2^WIDTH; counting range 0..MODULUS-1.

- clock  in  1  rising-edge clock.
- rst  in  1  reset, synchronous, active-high; clock clock.
- en  in  1  clock enable; when 0, Q holds in every mode.
- mode  in  2  0 = JK direct, 1 = count up, 2 = count down, 3 = load.
- J  in  WIDTH  per-bit J input (mode 0); load data (mode 3).
- K  in  WIDTH  per-bit K input (mode 0); ignored in modes 1-3.
- Q  out  WIDTH  registered state.
- Qb  out  WIDTH  ~Q, combinational.
- tc  out  1  terminal-count look-ahead, combinational.
- wrap  out  1  registered one-cycle pulse after a count wrap.

## Operation
- Priority at each rising edge: rst, then en, then mode.
- rst=1: Q <= 0 and wrap <= 0, regardless of en, mode, J or K.
- en=0 (no reset): Q holds and wrap <= 0.
- Mode 0, JK direct, per bit i on {J[i],K[i]}:
  - 00: hold.
  - 10: set to 1.
  - 01: clear to 0.
  - 11: toggle.
  - Bits are independent. Results at or above MODULUS are permitted and are not clamped.
- Mode 1, count up:
  - If Q >= MODULUS-1: Q <= 0 and wrap <= 1.
  - Otherwise: Q <= Q+1.
- Mode 2, count down:
  - If Q == 0: Q <= MODULUS-1 and wrap <= 1.
  - If Q >= MODULUS (out of range after JK mode): Q <= MODULUS-1 with wrap <= 0.
  - Otherwise: Q <= Q-1.
- Mode 3, load:
  - Q <= J if J < MODULUS, otherwise Q <= MODULUS-1.
  - wrap <= 0.
- wrap <= 0 on every edge not listed above as setting it.
- Qb == ~Q at all times, including during reset.
- tc = en & ~rst & ((mode==1 & Q >= MODULUS-1) | (mode==2 & Q == 0)). It is asserted exactly when the coming edge will wrap.
- Arithmetic is WIDTH bits wide. MODULUS-1 and the comparisons use a width of WIDTH+1 so that MODULUS = 2^WIDTH cannot overflow.
- Mode changes take effect on the same edge. Counting resumes from the current Q with no restart state.

## Timing
- Q latency: 1 cycle from the sampled inputs to the updated Q.
- wrap is asserted in the cycle after the edge where Q wrapped. It lasts exactly 1 cycle per wrap, so back-to-back wraps (MODULUS=2 at full speed) give a pulse in every other cycle.
- tc is valid in the same cycle as its inputs and has no registered delay.
- Cascading rule: drive the next stage's en from the lower stage's tc. The upper stage then advances on the same edge as the lower stage's wrap.
- Reset values:
  - Q = 0.
  - Qb = all ones.
  - wrap = 0.
  - tc = 0 (forced low while rst=1).
- Reset asserted mid-count:
  - Q is 0 on the next edge.
  - No wrap pulse is produced, even if that edge would have wrapped.
- Reset released: the first edge with rst=0 is a normal operating edge.

## Test plan
- Reset: run an up-count to Q=7, assert rst for 1 cycle with en=1 → Q=0, Qb=4'hF, wrap=0, tc=0. Release → counting restarts 1, 2, ….
- JK direct (WIDTH=4): Q=4'b0101, J=4'b0011, K=4'b1001 → Q=4'b0110. Bit 3 cleared, bit 2 held, bit 1 set, bit 0 toggled.
- Up wrap (MODULUS=10): count from 0 → Q sequence 1..9, 0. tc=1 only while Q=9. wrap=1 only in the cycle where Q=0 first appears.
- Down and out-of-range (MODULUS=10): from Q=0, down → Q=9, wrap=1.
  - JK-set Q to 13, then down → Q=9, wrap=0.
- Load clamp (MODULUS=10): load J=6 → Q=6; load J=12 → Q=9.
  - With en=0, load J=3 → Q holds at 9.
- Cascade: two instances with WIDTH=4, MODULUS=10, the upper stage's en driven from the lower stage's tc, run 100 cycles up → {upper,lower} goes 00..99, then 00. Upper wrap pulses once, at the 99→00 step.
